// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // funct3 values the ALU supports for R-type / OP-IMM
  function automatic logic funct3_is_alu(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Maps ALUOp plus instruction fields to an ALU operation and flags unsupported funct3.
module riscv_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_5,
  input  logic       funct7_5,
  output logic [2:0] alu_control,
  output logic       funct3_bad
);

  always_comb begin
    alu_control = ALU_ADD;
    funct3_bad  = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: funct3_bad  = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory port, tracks retired instructions and a sticky illegal flag.
module riscv_mc_control
  import riscv_mc_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_control,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [3:0]           state
);

  state_t               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [1:0]           alu_op;
  logic                 funct3_bad;
  logic                 rdy;
  logic                 is_alu_op;

  assign rdy       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign is_alu_op = (op == OP_RTYPE) || (op == OP_ITYPE);

  riscv_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_5        (op[5]),
    .funct7_5    (funct7_5),
    .alu_control (alu_control),
    .funct3_bad  (funct3_bad)
  );

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    instret_d  = instret_q;
    alu_op     = ALUOP_ADD;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        // Write enables stay low while reset is held, whatever mem_ready does
        ir_write   = rdy && !rst;
        pc_write   = rdy && !rst;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        illegal_d = illegal_q | funct3_bad;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        illegal_d = illegal_q | funct3_bad;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        // JAL also lands here and always writes the link register
        result_src = RES_ALUOUT;
        reg_write  = !(is_alu_op && !funct3_is_alu(funct3));
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000:  pc_write  = zero;
          3'b001:  pc_write  = !zero;
          default: illegal_d = 1'b1;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if ((state_d == S_FETCH) &&
        ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
         (state_q == S_ALUWB) || (state_q == S_BRANCH)))
      instret_d = instret_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench for riscv_mc_control: instruction vector table, hand-built
// corner sequences, and a randomized run against an instruction-level model.
module tb_riscv_mc_control;

  localparam int unsigned CW = 32;
  localparam int unsigned NV = 17;

  logic          clk, rst;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          funct7_5, zero, mem_ready;
  logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]    result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]    alu_control;
  logic          illegal;
  logic [CW-1:0] instret;
  logic [3:0]    state;

  int n_pass;
  int n_chk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         cyc;
    int         ret;
    logic       ill;
    int         rw;
    int         mw;
    logic [2:0] alu;
    logic       chk_alu;
    logic       pcb;
    logic [1:0] imm;
  } vec_t;

  vec_t       vecs[NV];
  logic [6:0] ops[9];

  riscv_mc_control #(.CNT_WIDTH(CW), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .illegal(illegal), .instret(instret), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Leaves the bench one time unit after a rising edge, in FETCH, reset released
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op = 7'b0000011; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, output int cyc, output int rw, output int mw,
                           output logic [2:0] alu, output logic pcb, output logic [1:0] imm);
    bit done;
    done = 1'b0;
    op = o; funct3 = f3; funct7_5 = f7; zero = z; mem_ready = 1'b1;
    cyc = 0; rw = 0; mw = 0; alu = 3'b111; pcb = 1'b0; imm = 2'b00;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (c == 0) imm = imm_src;
      if (state == 4'd6 || state == 4'd8) alu = alu_control;
      if (state == 4'd10) pcb = pc_write;
      rw += int'(reg_write);
      mw += int'(mem_write);
      @(posedge clk); #1;
      cyc++;
      if (state == 4'd0) done = 1'b1;
    end
    check("instr_returns_to_fetch", 64'(done), 64'(1));
  endtask

  task automatic table_test();
    int cyc, rw, mw;
    logic [2:0] alu;
    logic pcb;
    logic [1:0] imm;
    for (int i = 0; i < int'(NV); i++) begin
      do_reset();
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, cyc, rw, mw, alu, pcb, imm);
      check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d_instret", i), 64'(instret), 64'(vecs[i].ret));
      check($sformatf("v%0d_illegal", i), 64'(illegal), 64'(vecs[i].ill));
      check($sformatf("v%0d_regwrites", i), 64'(rw), 64'(vecs[i].rw));
      check($sformatf("v%0d_memwrites", i), 64'(mw), 64'(vecs[i].mw));
      check($sformatf("v%0d_imm_src", i), 64'(imm), 64'(vecs[i].imm));
      if (vecs[i].chk_alu) check($sformatf("v%0d_alu", i), 64'(alu), 64'(vecs[i].alu));
      if (vecs[i].op == 7'b1100011) check($sformatf("v%0d_branch_pc", i), 64'(pcb), 64'(vecs[i].pcb));
    end
  endtask

  task automatic lw_wait_test();
    logic rdy_seq[8];
    int   st_seq[8];
    rdy_seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    st_seq  = '{0, 0, 0, 1, 2, 3, 3, 4};
    do_reset();
    op = 7'b0000011; funct3 = 3'd2;
    for (int c = 0; c < 8; c++) begin
      mem_ready = rdy_seq[c];
      #1;
      check($sformatf("lw_wait_state_c%0d", c), 64'(state), 64'(st_seq[c]));
      check($sformatf("lw_wait_regwr_c%0d", c), 64'(reg_write), 64'(c == 7));
      if (c < 3) check($sformatf("lw_wait_irwr_c%0d", c), 64'(ir_write), 64'(c == 2));
      @(posedge clk); #1;
    end
    check("lw_wait_back_fetch", 64'(state), 64'(0));
    check("lw_wait_instret", 64'(instret), 64'(1));
  endtask

  task automatic add_sub_test();
    int cyc, rw, mw;
    logic [2:0] alu;
    logic pcb;
    logic [1:0] imm;
    do_reset();
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, cyc, rw, mw, alu, pcb, imm);
    check("addsub_add_alu", 64'(alu), 64'(3'b000));
    check("addsub_add_cyc", 64'(cyc), 64'(4));
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, cyc, rw, mw, alu, pcb, imm);
    check("addsub_sub_alu", 64'(alu), 64'(3'b001));
    check("addsub_sub_cyc", 64'(cyc), 64'(4));
    check("addsub_instret", 64'(instret), 64'(2));
  endtask

  task automatic sticky_and_reset_test();
    int cyc, rw, mw;
    logic [2:0] alu;
    logic pcb;
    logic [1:0] imm;
    do_reset();
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, cyc, rw, mw, alu, pcb, imm);
    check("illop_flag", 64'(illegal), 64'(1));
    check("illop_instret", 64'(instret), 64'(0));
    check("illop_no_writes", 64'(rw + mw), 64'(0));
    run_instr(7'b0110011, 3'd7, 1'b0, 1'b0, cyc, rw, mw, alu, pcb, imm);
    check("illop_sticky", 64'(illegal), 64'(1));
    check("illop_then_and_instret", 64'(instret), 64'(1));
    // Walk a load into MEMREAD, stall it, then reset mid-instruction
    op = 7'b0000011; funct3 = 3'd2; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #1;
    check("midrst_in_memread", 64'(state), 64'(3));
    rst = 1'b1;
    #1;
    check("midrst_state", 64'(state), 64'(0));
    check("midrst_instret", 64'(instret), 64'(0));
    check("midrst_illegal", 64'(illegal), 64'(0));
    check("midrst_outs",
          64'({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000}));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_state", 64'(state), 64'(0));
    check("postrst_outs", 64'({mem_req, ir_write, pc_write, reg_write, mem_write}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    mem_ready = 1'b1;
    #1;
    check("postrst_irwr_ready", 64'(ir_write), 64'(1));
  endtask

  task automatic wrap_test();
    int cyc, rw, mw;
    logic [2:0] alu;
    logic pcb;
    logic [1:0] imm;
    do_reset();
    force dut.instret_q = {CW{1'b1}};
    #1;
    release dut.instret_q;
    check("wrap_preload", 64'(instret), 64'({CW{1'b1}}));
    run_instr(7'b0110011, 3'd6, 1'b0, 1'b0, cyc, rw, mw, alu, pcb, imm);
    check("wrap_to_zero", 64'(instret), 64'(0));
  endtask

  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  task automatic random_test(input int n_instr);
    logic [6:0] o;
    logic [2:0] f3;
    logic f7, z, r, e_req, e_rw, e_mw, e_pc, is_alu, f3_ok, legal, e_ill;
    int path[$];
    int p, waits, e_ret;
    bit adv;
    do_reset();
    e_ret = 0;
    e_ill = 1'b0;
    for (int k = 0; k < n_instr; k++) begin
      o  = ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      is_alu = (o == 7'b0110011) || (o == 7'b0010011);
      f3_ok  = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
      path.delete();
      path.push_back(0);
      path.push_back(1);
      case (o)
        7'b0000011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
        7'b0100011: begin path.push_back(2); path.push_back(5); end
        7'b0110011: begin path.push_back(6); path.push_back(7); end
        7'b0010011: begin path.push_back(8); path.push_back(7); end
        7'b1101111: begin path.push_back(9); path.push_back(7); end
        7'b1100011: path.push_back(10);
        default: ;
      endcase
      legal = (path.size() > 2);
      op = o; funct3 = f3; funct7_5 = f7; zero = z;
      foreach (path[j]) begin
        p = path[j];
        waits = 0;
        adv = 1'b0;
        while (!adv) begin
          r = (waits >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
          mem_ready = r;
          #1;
          e_req = (p == 0) || (p == 3) || (p == 5);
          e_rw  = (p == 4) || ((p == 7) && (!is_alu || f3_ok));
          e_mw  = (p == 5);
          e_pc  = ((p == 0) && r) || (p == 9) ||
                  ((p == 10) && (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z)));
          check($sformatf("rnd%0d_state", k), 64'(state), 64'(p));
          check($sformatf("rnd%0d_ctrl", k), 64'({mem_req, reg_write, mem_write, pc_write}),
                64'({e_req, e_rw, e_mw, e_pc}));
          if (((p == 6) || (p == 8)) && f3_ok)
            check($sformatf("rnd%0d_alu", k), 64'(alu_control), 64'(exp_alu(o, f3, f7)));
          @(posedge clk); #1;
          adv = !e_req || r;
          waits++;
        end
      end
      if (legal) e_ret++;
      e_ill = e_ill | !legal | (is_alu && !f3_ok) | ((o == 7'b1100011) && (f3 > 3'd1));
      check($sformatf("rnd%0d_end_fetch", k), 64'(state), 64'(0));
      check($sformatf("rnd%0d_instret", k), 64'(instret), 64'(e_ret));
      check($sformatf("rnd%0d_illegal", k), 64'(illegal), 64'(e_ill));
    end
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    rst = 1'b0; op = 7'b0000011; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

    vecs[0]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, 5, 1, 1'b0, 1, 0, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{7'b0100011, 3'd2, 1'b0, 1'b0, 4, 1, 1'b0, 0, 1, 3'b000, 1'b0, 1'b0, 2'd1};
    vecs[2]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 4, 1, 1'b0, 1, 0, 3'b000, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{7'b0110011, 3'd0, 1'b1, 1'b0, 4, 1, 1'b0, 1, 0, 3'b001, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{7'b0110011, 3'd7, 1'b0, 1'b0, 4, 1, 1'b0, 1, 0, 3'b010, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{7'b0110011, 3'd6, 1'b0, 1'b0, 4, 1, 1'b0, 1, 0, 3'b011, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{7'b0110011, 3'd2, 1'b0, 1'b0, 4, 1, 1'b0, 1, 0, 3'b101, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, 4, 1, 1'b0, 1, 0, 3'b000, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{7'b0110011, 3'd1, 1'b0, 1'b0, 4, 1, 1'b1, 0, 0, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{7'b1101111, 3'd0, 1'b0, 1'b0, 4, 1, 1'b0, 1, 0, 3'b000, 1'b0, 1'b0, 2'd3};
    vecs[10] = '{7'b1100011, 3'd0, 1'b0, 1'b1, 3, 1, 1'b0, 0, 0, 3'b000, 1'b0, 1'b1, 2'd2};
    vecs[11] = '{7'b1100011, 3'd0, 1'b0, 1'b0, 3, 1, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0, 2'd2};
    vecs[12] = '{7'b1100011, 3'd1, 1'b0, 1'b0, 3, 1, 1'b0, 0, 0, 3'b000, 1'b0, 1'b1, 2'd2};
    vecs[13] = '{7'b1100011, 3'd1, 1'b0, 1'b1, 3, 1, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0, 2'd2};
    vecs[14] = '{7'b1100011, 3'd4, 1'b0, 1'b1, 3, 1, 1'b1, 0, 0, 3'b000, 1'b0, 1'b0, 2'd2};
    vecs[15] = '{7'b0000000, 3'd0, 1'b0, 1'b0, 2, 0, 1'b1, 0, 0, 3'b000, 1'b0, 1'b0, 2'd0};
    vecs[16] = '{7'b0010011, 3'd1, 1'b0, 1'b0, 4, 1, 1'b1, 0, 0, 3'b000, 1'b0, 1'b0, 2'd0};

    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100011, 7'b0000000, 7'b1110011, 7'b0110111};

    #2;
    rst = 1'b1;
    #2;
    check("reset_state", 64'(state), 64'(0));
    check("reset_instret", 64'(instret), 64'(0));
    check("reset_illegal", 64'(illegal), 64'(0));
    check("reset_outs",
          64'({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000}));

    table_test();
    lw_wait_test();
    add_sub_test();
    sticky_and_reset_test();
    wrap_test();
    random_test(150);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
